checkout_scan_controller: RTL

Sequences a checkout lane built around the UPC classifier datapath (U, P, C product bits plus the M security mark). Items are accepted one at a time over a valid/ready handshake, registered, then classified. Running item and discount counts are kept, and the lane halts in an alarm state when an item is classified stolen. The block sits between the debounced switch/key front end and the LEDR/HEX display logic in the board top level.

---
 rtl/checkout_pkg.sv | 10 +
 rtl/upc_classifier.sv | 12 +
 rtl/checkout_scan_controller.sv | 109 ++++++++++
 3 files changed

// File: rtl/checkout_pkg.sv
// checkout_pkg: shared types and defaults for the checkout lane controller
package checkout_pkg;
  localparam int CNT_W_DEFAULT = 4;
  typedef enum logic [2:0] {IDLE, SCAN, EVAL, ALARM, DONE} state_t;
  typedef struct packed {
    logic u;
    logic p;
    logic c;
  } upc_t;
endpackage

// File: rtl/upc_classifier.sv
// upc_classifier: combinational discount/stolen decode of one UPC item
module upc_classifier (
  input  logic u,
  input  logic p,
  input  logic c,
  input  logic m,
  output logic discount,
  output logic stolen
);
  assign discount = p | (u & c);
  assign stolen = ~m & ~discount;
endmodule

// File: rtl/checkout_scan_controller.sv
// checkout_scan_controller: item handshake, per-sale counters and stolen alarm FSM
module checkout_scan_controller
  import checkout_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             item_valid,
  input  logic [2:0]       upc,
  input  logic             marked,
  output logic             item_ready,
  input  logic             end_sale,
  input  logic             alarm_clear,
  output logic             alarm,
  output logic             discount_flag,
  output logic             busy,
  output logic             sale_done,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] discount_count,
  output logic [CNT_W-1:0] stolen_count
);
  state_t state_q, state_d;
  upc_t item_q, item_d;
  logic m_q, m_d;
  logic [CNT_W-1:0] item_cnt_q, item_cnt_d, disc_cnt_q, disc_cnt_d, stol_cnt_q, stol_cnt_d;
  logic alarm_q, alarm_d, dflag_q, dflag_d, done_q, done_d;
  logic accept, disc, stol;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  upc_classifier u_cls (
    .u(item_q.u), .p(item_q.p), .c(item_q.c), .m(m_q),
    .discount(disc), .stolen(stol)
  );
  assign item_ready = state_q inside {IDLE, SCAN, DONE};
  assign accept = item_valid & item_ready;
  always_comb begin
    state_d = state_q;
    item_d = item_q;
    m_d = m_q;
    item_cnt_d = item_cnt_q;
    disc_cnt_d = disc_cnt_q;
    stol_cnt_d = stol_cnt_q;
    alarm_d = alarm_q;
    dflag_d = dflag_q;
    done_d = 1'b0;
    if (accept) begin
      item_d = upc_t'(upc);
      m_d = marked;
      state_d = EVAL;
    end
    // an item taken outside SCAN opens a fresh sale
    if (accept && state_q != SCAN) begin
      item_cnt_d = '0;
      disc_cnt_d = '0;
      stol_cnt_d = '0;
    end
    case (state_q)
      SCAN: if (!item_valid && end_sale) begin
        state_d = DONE;
        done_d = 1'b1;
      end
      EVAL: begin
        item_cnt_d = sat_inc(item_cnt_q);
        disc_cnt_d = disc ? sat_inc(disc_cnt_q) : disc_cnt_q;
        stol_cnt_d = stol ? sat_inc(stol_cnt_q) : stol_cnt_q;
        dflag_d = disc;
        alarm_d = stol;
        state_d = stol ? ALARM : SCAN;
      end
      ALARM: if (alarm_clear) begin
        alarm_d = 1'b0;
        state_d = SCAN;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      item_q <= '0;
      m_q <= 1'b0;
      item_cnt_q <= '0;
      disc_cnt_q <= '0;
      stol_cnt_q <= '0;
      alarm_q <= 1'b0;
      dflag_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      item_q <= item_d;
      m_q <= m_d;
      item_cnt_q <= item_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      stol_cnt_q <= stol_cnt_d;
      alarm_q <= alarm_d;
      dflag_q <= dflag_d;
      done_q <= done_d;
    end
  end
  assign alarm = alarm_q;
  assign discount_flag = dflag_q;
  assign busy = state_q != IDLE;
  assign sale_done = done_q;
  assign item_count = item_cnt_q;
  assign discount_count = disc_cnt_q;
  assign stolen_count = stol_cnt_q;
endmodule
